maple_in: RTL and testbench

MAPLE_IN -- requirements
Module: maple_in

---
 rtl/maple_in_pkg.sv | 16 +
 rtl/maple_sync_edge.sv | 29 ++
 rtl/maple_in.sv | 171 +++++++++++++++++
 tb/tb_maple_in.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/maple_in_pkg.sv
// Shared types and protocol constants for the Maple bus receiver.
package maple_in_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_START,
    ST_DATA,
    ST_END
  } state_e;

  localparam int START_CLOCKS = 4;
  localparam int END_CLOCKS   = 2;
  localparam int BYTE_BITS    = 8;

endpackage

// File: rtl/maple_sync_edge.sv
// Two-flop synchronizer for one idle-high Maple line plus rise/fall detect.
module maple_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign lvl  = s2_q;
  assign rise = ~prev_q & s2_q;
  assign fall = prev_q & ~s2_q;

endmodule

// File: rtl/maple_in.sv
// Maple bus packet receiver: start/end pattern detection and byte assembly
// from the two alternating clock/data lines.
module maple_in
  import maple_in_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pin1,
  input  logic       pin5,
  input  logic       oe,
  input  logic       trigger_start,
  input  logic       trigger_end,
  output logic       active,
  output logic       start_detected,
  output logic       end_detected,
  output logic [7:0] fifo_data,
  output logic       data_produce
);

  logic [1:0] lvl, rise, fall;

  maple_sync_edge u_sync [1:0] (
    .clk  (clk),
    .rst  (rst),
    .din  ({pin5, pin1}),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  logic p1_lvl, p5_lvl, p1_rise, p5_rise, p1_fall, p5_fall;
  assign {p5_lvl, p1_lvl}   = lvl;
  assign {p5_rise, p1_rise} = rise;
  assign {p5_fall, p1_fall} = fall;

  state_e                 state_q, state_d;
  logic                   active_q, active_d;
  logic                   start_q, start_d, end_q, end_d, prod_q, prod_d;
  logic [7:0]             fifo_q, fifo_d;
  logic [BYTE_BITS-2:0]   shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [2:0]             clk_cnt_q, clk_cnt_d;
  logic [1:0]             end_cnt_q, end_cnt_d;
  logic                   phase_b_q, phase_b_d;
  logic                   take, bit_in;

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    end_d     = 1'b0;
    prod_d    = 1'b0;
    fifo_d    = fifo_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = clk_cnt_q;
    end_cnt_d = end_cnt_q;
    phase_b_d = phase_b_q;
    take      = 1'b0;
    bit_in    = 1'b0;

    case (state_q)
      ST_IDLE: if (trigger_start) state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (p1_fall && p5_lvl) begin
          state_d   = ST_START;
          clk_cnt_d = '0;
        end
      end
      ST_START: begin
        if (p5_fall && !p1_lvl && clk_cnt_q != 3'd7) clk_cnt_d = clk_cnt_q + 3'd1;
        if (p1_rise) begin
          if (clk_cnt_q >= 3'(START_CLOCKS)) begin
            start_d   = 1'b1;
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            end_cnt_d = '0;
            phase_b_d = 1'b0;
          end else begin
            state_d = ST_WAIT_START;
          end
        end
      end
      ST_DATA: begin
        // A run of pin1 falls with pin5 low and no pin5 fall between them is
        // the end marker; the partial byte is simply abandoned.
        if (p1_fall) begin
          if (!p5_lvl && end_cnt_q == 2'(END_CLOCKS - 1)) begin
            state_d = ST_END;
          end else begin
            end_cnt_d = p5_lvl ? 2'd0 : end_cnt_q + 2'd1;
            if (!phase_b_q) begin
              take   = 1'b1;
              bit_in = p5_lvl;
            end
          end
        end
        if (p5_fall) begin
          end_cnt_d = '0;
          if (phase_b_q) begin
            take   = 1'b1;
            bit_in = p1_lvl;
          end
        end
        if (take) begin
          shift_d   = {shift_q[BYTE_BITS-3:0], bit_in};
          phase_b_d = ~phase_b_q;
          if (bit_cnt_q == 3'(BYTE_BITS - 1)) begin
            fifo_d    = {shift_q, bit_in};
            prod_d    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_END: begin
        if (p5_rise) begin
          end_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d != ST_IDLE);

    if (oe || trigger_end) begin
      state_d  = ST_IDLE;
      active_d = 1'b0;
      start_d  = 1'b0;
      end_d    = 1'b0;
      prod_d   = 1'b0;
      fifo_d   = fifo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      active_q  <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      prod_q    <= 1'b0;
      fifo_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      clk_cnt_q <= '0;
      end_cnt_q <= '0;
      phase_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      start_q   <= start_d;
      end_q     <= end_d;
      prod_q    <= prod_d;
      fifo_q    <= fifo_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      clk_cnt_q <= clk_cnt_d;
      end_cnt_q <= end_cnt_d;
      phase_b_q <= phase_b_d;
    end
  end

  assign active         = active_q;
  assign start_detected = start_q;
  assign end_detected   = end_q;
  assign data_produce   = prod_q;
  assign fifo_data      = fifo_q;

endmodule

// File: tb/tb_maple_in.sv
// Directed bench for maple_in; strobes are checked by a scoreboard monitor.
module tb_maple_in;

  logic       clk = 1'b0, rst = 1'b1;
  logic       pin1 = 1'b1, pin5 = 1'b1, oe = 1'b0;
  logic       trigger_start = 1'b0, trigger_end = 1'b0;
  logic       active, start_detected, end_detected, data_produce;
  logic [7:0] fifo_data;

  maple_in dut (
    .clk            (clk),
    .rst            (rst),
    .pin1           (pin1),
    .pin5           (pin5),
    .oe             (oe),
    .trigger_start  (trigger_start),
    .trigger_end    (trigger_end),
    .active         (active),
    .start_detected (start_detected),
    .end_detected   (end_detected),
    .fifo_data      (fifo_data),
    .data_produce   (data_produce)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_START = 1, K_END = 2, K_DATA = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe is registered three clocks after the raw edge driven now.
  task automatic expect_ev(input int kind, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.at   = cyc + 3;
    q.push_back(e);
  endtask

  task automatic drv1(input logic v, input int kind = 0, input logic [7:0] d = 8'h00);
    pin1 = v;
    if (kind != 0) expect_ev(kind, d);
    tick(4);
  endtask

  task automatic drv5(input logic v, input int kind = 0, input logic [7:0] d = 8'h00);
    pin5 = v;
    if (kind != 0) expect_ev(kind, d);
    tick(4);
  endtask

  task automatic arm(input logic want);
    trigger_start = 1'b1;
    tick(1);
    trigger_start = 1'b0;
    check("arm_active", active, want);
    tick(2);
  endtask

  task automatic pulse_end();
    trigger_end = 1'b1;
    tick(1);
    trigger_end = 1'b0;
    check("trigger_end_active", active, 0);
    tick(2);
  endtask

  task automatic start_pat(input int pulses, input bit ok);
    drv1(1'b0);
    repeat (pulses) begin
      drv5(1'b0);
      drv5(1'b1);
    end
    drv1(1'b1, ok ? K_START : 0);
  endtask

  task automatic bit_a(input logic b);
    drv1(1'b1);
    drv5(b);
    drv1(1'b0);
  endtask

  task automatic bit_b(input logic c, input int kind = 0, input logic [7:0] d = 8'h00);
    drv5(1'b1);
    drv1(c);
    drv5(1'b0, kind, d);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    for (int i = 7; i > 0; i -= 2) begin
      bit_a(b[i]);
      bit_b(b[i-1], (i == 1 && ok) ? K_DATA : 0, b);
    end
  endtask

  task automatic end_pat(input bit ok);
    drv1(1'b1);
    drv5(1'b0);
    drv1(1'b0);
    drv1(1'b1);
    drv1(1'b0);
    drv1(1'b1);
    drv5(1'b1, ok ? K_END : 0);
  endtask

  task automatic pop(input int kind);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_strobe: got kind=%0d at cyc=%0d, want none", kind, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.at != cyc || (kind == K_DATA && e.data != fifo_data)) begin
        bad++;
        $display("FAIL strobe: got kind=%0d cyc=%0d data=%02h want kind=%0d cyc=%0d data=%02h",
                 kind, cyc, fifo_data, e.kind, e.at, e.data);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (start_detected) pop(K_START);
      if (end_detected)   pop(K_END);
      if (data_produce)   pop(K_DATA);
    end
  end

  initial begin
    tick(2);
    check("reset_outs", {active, start_detected, end_detected, data_produce, fifo_data}, 0);
    rst = 1'b0;
    tick(2);

    // full packet
    arm(1'b1);
    start_pat(4, 1'b1);
    check("active_after_start", active, 1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h08, 1'b1);
    end_pat(1'b1);
    check("active_after_end", active, 0);
    check("fifo_hold", fifo_data, 8'h08);

    // short start pattern rejected, then a valid one accepted
    arm(1'b1);
    start_pat(3, 1'b0);
    check("active_after_short", active, 1);
    start_pat(4, 1'b1);
    pulse_end();

    // abort mid-byte
    arm(1'b1);
    start_pat(4, 1'b1);
    bit_a(1'b1); bit_b(1'b1); bit_a(1'b1); bit_b(1'b1); bit_a(1'b1);
    pulse_end();
    bit_b(1'b1); bit_a(1'b1); bit_b(1'b1);
    end_pat(1'b0);
    check("active_after_abort", active, 0);

    // trigger_end beats trigger_start
    trigger_start = 1'b1;
    trigger_end   = 1'b1;
    tick(1);
    trigger_start = 1'b0;
    trigger_end   = 1'b0;
    check("both_triggers_active", active, 0);
    tick(2);

    // driver enabled: receiver stays idle
    oe = 1'b1;
    arm(1'b0);
    start_pat(4, 1'b0);
    send_byte(8'hA5, 1'b0);
    end_pat(1'b0);
    check("oe_active", active, 0);
    oe = 1'b0;
    tick(2);
    check("oe_release_active", active, 0);
    check("oe_fifo_hold", fifo_data, 8'h08);

    // reset mid-packet
    arm(1'b1);
    start_pat(4, 1'b1);
    bit_a(1'b1);
    bit_b(1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {active, start_detected, end_detected, data_produce, fifo_data}, 0);
    pin1 = 1'b1;
    pin5 = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    check("post_rst_active", active, 0);

    tick(8);
    check("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
